hyper_ram_cmd_scheduler: RTL
============================

Name: hyper_ram_cmd_scheduler

Overview:
Multi-channel successor to the single-queue HyperRAM transaction sequencer. It accepts read and write commands from NUM_CH independent clients and arbitrates between them round-robin. Commands longer than MAX_BURST are split into driver-sized bursts. For each burst it builds the 48-bit CA word, sequences the hyperRamDriver handshake and steers that driver's FIFO request strobes to the owning channel. It sits between the client command interfaces and hyperRamDriver.

Parameters:
NUM_CH, 4, number of client channels (1..8)
ADDR_W, 23, word address width (16-bit words)
REQ_LEN_W, 16, client byte-length width
DRV_LEN_W, 11, driver bytesToTransfer width
MAX_BURST, 1280, max bytes per driver transaction (even, < 2**DRV_LEN_W)
LINEAR, 0, CA bit 45 value (0 wrapped, 1 linear)
TIMEOUT, 4096, cycles allowed from drv_enable rise to drv_process_done

Ports:
clk_50  in  1  system clock
reset  in  1  async active-high reset
req_valid  in  NUM_CH  per-channel command valid
req_ready  out  NUM_CH  per-channel command accepted (valid&ready = transfer)
req_rw  in  NUM_CH  1 read, 0 write
req_addr  in  NUM_CH*ADDR_W  start word address, channel i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_CH*REQ_LEN_W  byte count, packed likewise
cmd_done  out  NUM_CH  1-cycle pulse when the whole command completes
cmd_err  out  NUM_CH  1-cycle pulse with cmd_done if any burst timed out
busy  out  1  command in progress
active_ch  out  3  owning channel index (valid while busy)
drv_enable  out  1  hyperRamDriver enable
drv_rw_mode  out  1  hyperRamDriver rwMode
drv_ca  out  48  hyperRamDriver caInfo
drv_len  out  DRV_LEN_W  hyperRamDriver bytesToTransfer
drv_setup_done  in  1  hyperRamDriver setupDone
drv_transfering  in  1  hyperRamDriver dataTransfering
drv_process_done  in  1  hyperRamDriver processDone (treated as synchronous level)
rdfifo_wreq  out  NUM_CH  read-data FIFO write enable per channel
wrfifo_rreq  out  NUM_CH  write-data FIFO read enable per channel

Behaviour:
- Reset (async, active-high): all outputs 0, FSM IDLE, RR pointer 0, internal counters 0. Reset mid-transaction drops the command with no cmd_done.
- req_ready is high only in IDLE, only for the channel granted that cycle. Grant goes to the first valid channel scanning upward from rr_ptr+1, modulo NUM_CH. On accept, rr_ptr takes the granted index. The accepting cycle latches rw, addr, len and channel.
- States and transitions:
  - IDLE: on accept go to LOAD. If len==0, skip LOAD and go to DONE.
  - LOAD: chunk = min(remaining, MAX_BURST). drv_len=chunk. drv_rw_mode=rw. CA word: [47]=rw, [46]=0, [45]=LINEAR, [44:36]=0, [35:16]=addr[22:3], [15:3]=0, [2:0]=addr[2:0]. Go to SETUP.
  - SETUP: drv_enable=1 and the timeout counter starts. On drv_setup_done go to XFER.
  - XFER: assert rdfifo_wreq[ch] if rw=1, otherwise wrfifo_rreq[ch]; all other bits stay 0. Strobes stay high until the driver finishes. Go to WAIT.
  - WAIT: when drv_process_done=1, drop drv_enable and strobes, set remaining-=chunk and addr+=ceil(chunk/2) (wraps mod 2**ADDR_W), then go to NEXT. If drv_transfering falls without process_done, stay in WAIT.
  - NEXT: if remaining>0, go to LOAD; otherwise go to DONE.
  - DONE: pulse cmd_done[ch] plus cmd_err[ch] if the error flag is set, clear busy, return to IDLE.
- Timeout: when the counter reaches TIMEOUT in SETUP/XFER/WAIT, force drv_enable=0, clear strobes, set the error flag, abandon the remaining bursts and go to DONE.
- busy=1 from LOAD through DONE inclusive. active_ch is held until the next accept.
- drv_enable stays low for at least one cycle between bursts (the NEXT and LOAD cycles).
- The address crosses the 2**ADDR_W boundary by wrap-around; no error.

Test Plan:
- Single read, ch0 addr 0x000010 len 64 -> one burst, drv_ca=0x800000000000|... with [2:0]=0 and [35:16]=0x2; drv_len=64; rdfifo_wreq[0] high during XFER; cmd_done[0] pulse.
- Write, ch2 len 3000, MAX_BURST 1280 -> bursts of 1280, 1280, 440 with addresses A, A+640, A+1280; wrfifo_rreq[2] only; one cmd_done[2].
- All 4 channels valid simultaneously after reset -> grant order 1, 2, 3, 0; each req_ready one cycle.
- Command with len 0 on ch1 -> no drv_enable; cmd_done[1] two cycles after accept.
- Driver never asserts process_done, TIMEOUT=16 -> drv_enable drops at cycle 16; cmd_done and cmd_err pulse together; the next channel is served.
- Reset asserted during XFER -> all outputs 0 immediately; no cmd_done; next command runs normally.

Source files
------------

// File: rtl/hyper_ram_cmd_scheduler.sv
// Round-robin command scheduler in front of hyperRamDriver: splits client commands
// into driver-sized bursts, builds the CA word and steers FIFO strobes to the owner.
module hyper_ram_cmd_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 23,
    parameter int REQ_LEN_W = 16,
    parameter int DRV_LEN_W = 11,
    parameter int MAX_BURST = 1280,
    parameter int LINEAR    = 0,
    parameter int TIMEOUT   = 4096
) (
    input  logic                        i_clk_50,
    input  logic                        i_reset,
    input  logic [NUM_CH-1:0]           i_req_valid,
    output logic [NUM_CH-1:0]           o_req_ready,
    input  logic [NUM_CH-1:0]           i_req_rw,
    input  logic [NUM_CH*ADDR_W-1:0]    i_req_addr,
    input  logic [NUM_CH*REQ_LEN_W-1:0] i_req_len,
    output logic [NUM_CH-1:0]           o_cmd_done,
    output logic [NUM_CH-1:0]           o_cmd_err,
    output logic                        o_busy,
    output logic [2:0]                  o_active_ch,
    output logic                        o_drv_enable,
    output logic                        o_drv_rw_mode,
    output logic [47:0]                 o_drv_ca,
    output logic [DRV_LEN_W-1:0]        o_drv_len,
    input  logic                        i_drv_setup_done,
    input  logic                        i_drv_transfering,
    input  logic                        i_drv_process_done,
    output logic [NUM_CH-1:0]           o_rdfifo_wreq,
    output logic [NUM_CH-1:0]           o_wrfifo_rreq,
    output logic [2:0]                  o_dbg_state,
    output logic                        o_dbg_xfer_seen
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_XFER, S_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_rr_ptr;
    logic [2:0]             r_ch;
    logic                   r_rw;
    logic                   r_err;
    logic                   r_xfer_seen;
    logic [ADDR_W-1:0]      r_addr;
    logic [REQ_LEN_W-1:0]   r_remaining;
    logic [REQ_LEN_W-1:0]   r_chunk;
    logic [TMO_W-1:0]       r_tmo_cnt;

    logic [7:0]             w_valid8;
    logic                   w_grant_vld;
    logic [2:0]             w_grant_idx;
    logic                   w_accept;
    logic [NUM_CH-1:0]      w_grant_oh;
    logic [NUM_CH-1:0]      w_ch_oh;
    logic                   w_req_rw;
    logic [ADDR_W-1:0]      w_req_addr;
    logic [REQ_LEN_W-1:0]   w_req_len;
    logic [REQ_LEN_W-1:0]   w_chunk;
    logic                   w_tmo_hit;

    assign w_valid8 = 8'(i_req_valid);

    // Scan downward so the last hit is the closest channel after r_rr_ptr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (w_valid8[3'((int'(r_rr_ptr) + k) % NUM_CH)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = 3'((int'(r_rr_ptr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        w_req_rw   = 1'b0;
        w_req_addr = '0;
        w_req_len  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (3'(c) == w_grant_idx) begin
                w_req_rw   = i_req_rw[c];
                w_req_addr = i_req_addr[c*ADDR_W +: ADDR_W];
                w_req_len  = i_req_len[c*REQ_LEN_W +: REQ_LEN_W];
            end
        end
    end

    // Handshake: a command transfers on a rising edge where valid[i] and ready[i]
    // are both high; ready is a combinational grant offered only while IDLE.
    assign w_accept    = (r_state == S_IDLE) && w_grant_vld && !i_reset;
    assign w_grant_oh  = NUM_CH'(1) << w_grant_idx;
    assign w_ch_oh     = NUM_CH'(1) << r_ch;
    assign o_req_ready = w_accept ? w_grant_oh : '0;

    assign w_chunk   = (r_remaining > REQ_LEN_W'(MAX_BURST)) ? REQ_LEN_W'(MAX_BURST) : r_remaining;
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    assign o_dbg_state     = r_state;
    assign o_dbg_xfer_seen = r_xfer_seen;

    always_ff @(posedge i_clk_50 or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_ch          <= '0;
            r_rw          <= 1'b0;
            r_err         <= 1'b0;
            r_xfer_seen   <= 1'b0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_chunk       <= '0;
            r_tmo_cnt     <= '0;
            o_cmd_done    <= '0;
            o_cmd_err     <= '0;
            o_busy        <= 1'b0;
            o_active_ch   <= '0;
            o_drv_enable  <= 1'b0;
            o_drv_rw_mode <= 1'b0;
            o_drv_ca      <= '0;
            o_drv_len     <= '0;
            o_rdfifo_wreq <= '0;
            o_wrfifo_rreq <= '0;
        end else begin
            o_cmd_done <= '0;
            o_cmd_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ch        <= w_grant_idx;
                        r_rr_ptr    <= w_grant_idx;
                        o_active_ch <= w_grant_idx;
                        r_rw        <= w_req_rw;
                        r_addr      <= w_req_addr;
                        r_remaining <= w_req_len;
                        r_err       <= 1'b0;
                        o_busy      <= 1'b1;
                        r_state     <= (w_req_len == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_chunk       <= w_chunk;
                    o_drv_len     <= DRV_LEN_W'(w_chunk);
                    o_drv_rw_mode <= r_rw;
                    o_drv_ca      <= {r_rw, 1'b0, 1'(LINEAR), 9'd0,
                                      20'(r_addr[ADDR_W-1:3]), 13'd0, r_addr[2:0]};
                    o_drv_enable  <= 1'b1;
                    r_tmo_cnt     <= '0;
                    r_xfer_seen   <= 1'b0;
                    r_state       <= S_SETUP;
                end
                S_SETUP, S_XFER, S_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (i_drv_transfering) begin
                        r_xfer_seen <= 1'b1;
                    end
                    // A completion in the same cycle as the timeout still counts as success.
                    if (r_state == S_WAIT && i_drv_process_done) begin
                        o_drv_enable  <= 1'b0;
                        o_rdfifo_wreq <= '0;
                        o_wrfifo_rreq <= '0;
                        r_remaining   <= r_remaining - r_chunk;
                        r_addr        <= r_addr + ADDR_W'((r_chunk + 1'b1) >> 1);
                        r_state       <= S_NEXT;
                    end else if (w_tmo_hit) begin
                        o_drv_enable  <= 1'b0;
                        o_rdfifo_wreq <= '0;
                        o_wrfifo_rreq <= '0;
                        r_err         <= 1'b1;
                        r_state       <= S_DONE;
                    end else if (r_state == S_SETUP && i_drv_setup_done) begin
                        o_rdfifo_wreq <= r_rw ? w_ch_oh : '0;
                        o_wrfifo_rreq <= r_rw ? '0 : w_ch_oh;
                        r_state       <= S_XFER;
                    end else if (r_state == S_XFER) begin
                        r_state <= S_WAIT;
                    end
                end
                S_NEXT: begin
                    r_state <= (r_remaining != '0) ? S_LOAD : S_DONE;
                end
                S_DONE: begin
                    o_cmd_done <= w_ch_oh;
                    o_cmd_err  <= r_err ? w_ch_oh : '0;
                    o_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
